// File: rtl/pattern_pkg.sv
// pattern_pkg: shared pattern-row geometry and types for foreground and PMF logic
package pattern_pkg;
   localparam int PATTERN_PIXELS = 8;
   localparam int PATTERN_BPP = 2;
   localparam int PATTERN_LW = PATTERN_PIXELS * PATTERN_BPP;
   typedef logic [PATTERN_BPP-1:0] pixel_t;
   typedef pixel_t [PATTERN_PIXELS-1:0] pattern_line_t;
endpackage

// File: rtl/pattern_pixel_reverse.sv
// pattern_pixel_reverse: combinational whole-pixel reversal of a packed row, bits within a pixel kept
module pattern_pixel_reverse
   import pattern_pkg::*;
#(
   parameter int PIXELS = PATTERN_PIXELS,
   parameter int BPP = PATTERN_BPP
) (
   input  logic [PIXELS*BPP-1:0] line_in,
   output logic [PIXELS*BPP-1:0] line_out
);
   for (genvar i = 0; i < PIXELS; i++) begin : g_px
      assign line_out[i*BPP +: BPP] = line_in[(PIXELS-1-i)*BPP +: BPP];
   end
endmodule

// File: rtl/pattern_hflipper.sv
// pattern_hflipper: registered optional horizontal mirror of a sprite pattern row; PATTERN_HFLIPPER_OPAQUE_MASK_EN adds opaque_mask
module pattern_hflipper
   import pattern_pkg::*;
#(
   parameter int PIXELS = PATTERN_PIXELS,
   parameter int BPP = PATTERN_BPP
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [PIXELS*BPP-1:0] line_in,
   input  logic                  hflip,
   output logic                  out_valid,
   output logic [PIXELS*BPP-1:0] line_out
`ifdef PATTERN_HFLIPPER_OPAQUE_MASK_EN
   ,
   output logic [PIXELS-1:0]     opaque_mask
`endif
);
   logic [PIXELS*BPP-1:0] rev, nxt;
   pattern_pixel_reverse #(.PIXELS(PIXELS), .BPP(BPP)) u_rev (.line_in(line_in), .line_out(rev));
   assign nxt = hflip ? rev : line_in;
`ifdef PATTERN_HFLIPPER_OPAQUE_MASK_EN
   logic [PIXELS-1:0] mask_nxt;
   for (genvar j = 0; j < PIXELS; j++) begin : g_mask
      assign mask_nxt[j] = |nxt[j*BPP +: BPP];
   end
   // capture row and opacity together on accepted inputs; hold otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         line_out <= '0;
         opaque_mask <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            line_out <= nxt;
            opaque_mask <= mask_nxt;
         end
      end
   end
`else
   // capture the row on accepted inputs; hold otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         line_out <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) line_out <= nxt;
      end
   end
`endif
endmodule

// File: tb/tb_pattern_hflipper.sv
// tb_pattern_hflipper: directed and randomized checks of pattern_hflipper against a pixel-list model
module tb_pattern_hflipper;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic [15:0] line_in = '0;
   logic hflip = 1'b0;
   logic out_valid;
   logic [15:0] line_out;
   int errors = 0;
   int checks = 0;
`ifdef PATTERN_HFLIPPER_OPAQUE_MASK_EN
   logic [7:0] opaque_mask;
`endif

   pattern_hflipper dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .line_in(line_in),
      .hflip(hflip),
      .out_valid(out_valid),
      .line_out(line_out)
`ifdef PATTERN_HFLIPPER_OPAQUE_MASK_EN
      ,
      .opaque_mask(opaque_mask)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] model_row(input logic [15:0] l, input logic h);
      int px[8];
      logic [15:0] r = '0;
      for (int p = 0; p < 8; p++) px[p] = int'((l >> (14 - 2*p)) & 16'd3);
      for (int p = 0; p < 8; p++) r |= 16'(h ? px[7-p] : px[p]) << (14 - 2*p);
      return r;
   endfunction

   function automatic logic [7:0] model_mask(input logic [15:0] row);
      logic [7:0] m = '0;
      for (int p = 0; p < 8; p++) m[7-p] = ((row >> (14 - 2*p)) & 16'd3) != 0;
      return m;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] exp_line, input logic exp_valid);
      checks++;
      if (line_out !== exp_line || out_valid !== exp_valid) begin
         errors++;
         $display("FAIL %s: line_out=%h out_valid=%b, expected line_out=%h out_valid=%b", name, line_out, out_valid, exp_line, exp_valid);
      end
`ifdef PATTERN_HFLIPPER_OPAQUE_MASK_EN
      checks++;
      if (opaque_mask !== model_mask(exp_line)) begin
         errors++;
         $display("FAIL %s mask: opaque_mask=%h, expected %h", name, opaque_mask, model_mask(exp_line));
      end
`endif
   endtask

   task automatic drive(input logic v, input logic [15:0] l, input logic h);
      in_valid = v;
      line_in = l;
      hflip = h;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 16'hFFFF, 1'b1);
      drive(1'b1, 16'hFFFF, 1'b0);
      chk("reset", 16'h0000, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_pass();
      drive(1'b1, 16'hC0AB, 1'b0);
      chk("pass", 16'hC0AB, 1'b1);
   endtask

   task automatic test_mirror();
      drive(1'b1, 16'hC0AB, 1'b1);
      chk("mirror", 16'hEA03, 1'b1);
`ifdef PATTERN_HFLIPPER_OPAQUE_MASK_EN
      checks++;
      if (opaque_mask !== 8'hF1) begin
         errors++;
         $display("FAIL mirror mask const: opaque_mask=%h, expected f1", opaque_mask);
      end
`endif
   endtask

   task automatic test_hold();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 16'h5555, 1'b1);
         chk("hold", 16'hEA03, 1'b0);
      end
   endtask

   task automatic test_intra();
      drive(1'b1, 16'h1B00, 1'b1);
      chk("intra", 16'h00E4, 1'b1);
      drive(1'b1, 16'h00E4, 1'b1);
      chk("intra_back", 16'h1B00, 1'b1);
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 16'hEAAB, 1'b1);
      chk("stream0", 16'hEAAB, 1'b1);
      drive(1'b1, 16'h0003, 1'b1);
      chk("stream1", 16'hC000, 1'b1);
      drive(1'b1, 16'h8000, 1'b0);
      chk("stream2", 16'h8000, 1'b1);
      rst = 1'b1;
      drive(1'b1, 16'h1234, 1'b1);
      chk("mid_reset", 16'h0000, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_random();
      logic [15:0] held = '0;
      logic [15:0] l;
      logic v, h, r;
      for (int i = 0; i < 300; i++) begin
         l = 16'($urandom);
         v = ($urandom_range(0, 3) != 0);
         h = 1'($urandom);
         r = ($urandom_range(0, 49) == 0);
         rst = r;
         drive(v, l, h);
         if (r) held = '0;
         else if (v) held = model_row(l, h);
         chk("random", held, v && !r);
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_pass();
      test_mirror();
      test_hold();
      test_intra();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
